lsu_mem_initiator: RTL and testbench

- Bus initiator between the core's load/store stage and the word-addressed data memory on the de1-soc target.
- The memory has a combinational read and a synchronous full-word write. It cannot write bytes or halfwords.
- This block turns byte, halfword and word loads/stores into word accesses.
- Sub-word stores use read-modify-write. Loads are sign- or zero-extended. Misaligned and illegal-size requests are flagged as faults and never reach memory.

---
 rtl/lsu_mem_initiator.sv | 224 ++++++++++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: turns byte/half/word loads and stores from the core's
// load/store stage into full-word accesses on a word-addressed data memory
// (combinational read, synchronous full-word write). Sub-word stores use
// read-modify-write; loads are sign- or zero-extended; misaligned and
// illegal-size requests complete as faults without touching memory.
//
// Optional build macro LSU_STATS_EN adds stat_loads/stat_stores/stat_faults.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so at most one request is in flight. All
// req_* fields are captured at accept and later changes are ignored. Completion
// is a single-cycle rsp_valid pulse, with rsp_fault/rsp_rdata qualified by it.
module lsu_mem_initiator #(
    parameter int ADDR_MASK_LSB = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data,
`ifdef LSU_STATS_EN
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_faults,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_READ       = 3'd1;
    localparam logic [2:0] S_WRITE      = 3'd2;
    localparam logic [2:0] S_RESP       = 3'd3;
    localparam logic [2:0] S_FAULT_RESP = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] WORD_MASK = ~((32'd1 << ADDR_MASK_LSB) - 32'd1);

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic        write_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        accept;
    logic        req_fault;
    logic [31:0] merged_word;
    logic [31:0] load_value;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    // Fault classification of the incoming request, used at the accept edge.
    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SZ_HALF: req_fault = req_address[0];
            SZ_WORD: req_fault = (req_address[1:0] != 2'b00);
            SZ_BYTE: req_fault = 1'b0;
            default: req_fault = 1'b1;
        endcase
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_fault)
                        state_next = S_FAULT_RESP;
                    else if (req_write && (req_size == SZ_WORD))
                        state_next = S_WRITE;
                    else
                        state_next = S_READ;
                end
            end
            S_READ:       state_next = write_q ? S_WRITE : S_RESP;
            S_WRITE:      state_next = S_RESP;
            S_RESP:       state_next = S_IDLE;
            S_FAULT_RESP: state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Request latches, loaded only at accept and held until the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else if (accept) begin
            write_q    <= req_write;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_address;
            wdata_q    <= req_wdata;
        end
    end

    // Memory word captured at the end of the READ cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            word_q <= 32'd0;
        else if (state == S_READ)
            word_q <= mem_read_data;
    end

    // Store merge: replace only the addressed lane of the captured word.
    always_comb begin
        merged_word = word_q;
        case (size_q)
            SZ_BYTE: begin
                case (addr_q[1:0])
                    2'd0:    merged_word[7:0]   = wdata_q[7:0];
                    2'd1:    merged_word[15:8]  = wdata_q[7:0];
                    2'd2:    merged_word[23:16] = wdata_q[7:0];
                    default: merged_word[31:24] = wdata_q[7:0];
                endcase
            end
            SZ_HALF: begin
                if (addr_q[1])
                    merged_word[31:16] = wdata_q[15:0];
                else
                    merged_word[15:0]  = wdata_q[15:0];
            end
            default: merged_word = wdata_q;
        endcase
    end

    // Load extraction with sign or zero extension.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = 8'd0;
        lane_h = 16'd0;
        load_value = word_q;
        case (addr_q[1:0])
            2'd0:    lane_b = word_q[7:0];
            2'd1:    lane_b = word_q[15:8];
            2'd2:    lane_b = word_q[23:16];
            default: lane_b = word_q[31:24];
        endcase
        lane_h = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (size_q)
            SZ_BYTE: load_value = {{24{lane_b[7] & ~unsigned_q}}, lane_b};
            SZ_HALF: load_value = {{16{lane_h[15] & ~unsigned_q}}, lane_h};
            default: load_value = word_q;
        endcase
    end

    // Outputs decoded from state so reset drops them immediately.
    always_comb begin
        mem_address      = 32'd0;
        mem_write_data   = 32'd0;
        mem_write_enable = 1'b0;
        rsp_valid        = 1'b0;
        rsp_fault        = 1'b0;
        rsp_rdata        = 32'd0;
        case (state)
            S_READ: mem_address = addr_q & WORD_MASK;
            S_WRITE: begin
                mem_address      = addr_q & WORD_MASK;
                mem_write_data   = merged_word;
                mem_write_enable = 1'b1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = write_q ? 32'd0 : load_value;
            end
            S_FAULT_RESP: begin
                rsp_valid = 1'b1;
                rsp_fault = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef LSU_STATS_EN
    // Completion counters; faulted requests count only as faults.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_loads  <= 32'd0;
            stat_stores <= 32'd0;
            stat_faults <= 32'd0;
        end else begin
            if (state == S_RESP && !write_q)
                stat_loads <= stat_loads + 32'd1;
            if (state == S_RESP && write_q)
                stat_stores <= stat_stores + 32'd1;
            if (state == S_FAULT_RESP)
                stat_faults <= stat_faults + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Testbench for lsu_mem_initiator: directed cases plus randomized requests,
// checked against a byte-level reference memory model.
module tb_lsu_mem_initiator;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;
    logic [2:0]  dbg_state;
`ifdef LSU_STATS_EN
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_faults;
`endif

    int check_count = 0;
    int fail_count  = 0;
    int we_count    = 0;

    logic [31:0] tb_mem  [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_q[$];

    int exp_loads  = 0;
    int exp_stores = 0;
    int exp_faults = 0;

    lsu_mem_initiator #(.ADDR_MASK_LSB(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_fault        (rsp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data),
`ifdef LSU_STATS_EN
        .stat_loads       (stat_loads),
        .stat_stores      (stat_stores),
        .stat_faults      (stat_faults),
`endif
        .dbg_state        (dbg_state)
    );

    // Clock and memory stand-in.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = tb_mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            tb_mem[mem_address[9:2]] <= mem_write_data;
            we_count <= we_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain shift/mask arithmetic on a word array.
    function automatic bit ref_fault(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd3) || (size == 2'd1 && (a % 2) != 0) || (size == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns, input logic [31:0] a);
        logic [31:0] w, v;
        w = ref_mem[(a / 4) % 256];
        if (size == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w, m;
        int sh;
        w = ref_mem[(a / 4) % 256];
        if (size == 2'd0) begin
            sh = 8 * (a % 4);
            m = 32'hFF << sh;
            w = (w & ~m) | ((d & 32'hFF) << sh);
        end else if (size == 2'd1) begin
            sh = 16 * ((a / 2) % 2);
            m = 32'hFFFF << sh;
            w = (w & ~m) | ((d & 32'hFFFF) << sh);
        end else begin
            w = d;
        end
        ref_mem[(a / 4) % 256] = w;
    endtask

    // Driver: issue one request, wait for its response, check latency and data.
    task automatic do_req(input string tag, input bit wr, input logic [1:0] size,
                          input bit uns, input logic [31:0] a, input logic [31:0] d);
        int lat, exp_lat, we0;
        bit flt;
        logic [31:0] exp_data;
        flt = ref_fault(size, a);
        exp_data = (flt || wr) ? 32'd0 : ref_load(size, uns, a);
        if (flt) exp_lat = 1;
        else if (wr && size != 2'd2) exp_lat = 3;
        else exp_lat = 2;
        exp_q.push_back(exp_data);
        @(negedge clk);
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = size;
        req_unsigned = uns; req_address = a; req_wdata = d;
        we0 = we_count;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_address = $urandom;
        req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 8);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".rdata"}, rsp_rdata, exp_q.pop_front());
        chk({tag, ".fault"}, {31'd0, rsp_fault}, {31'd0, flt});
        chk({tag, ".writes"}, we_count - we0, (wr && !flt) ? 1 : 0);
        @(negedge clk);
        chk({tag, ".pulse"}, {31'd0, rsp_valid}, 32'd0);
        if (flt) exp_faults++;
        else if (wr) begin exp_stores++; ref_store(size, a, d); end
        else exp_loads++;
    endtask

    task automatic check_stats(input string tag);
`ifdef LSU_STATS_EN
        chk({tag, ".stat_loads"}, stat_loads, exp_loads);
        chk({tag, ".stat_stores"}, stat_stores, exp_stores);
        chk({tag, ".stat_faults"}, stat_faults, exp_faults);
`endif
    endtask

    initial begin
        int accepts, rsps, cyc, last, we0;
        logic [31:0] w0;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_address = 0; req_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            w0 = $urandom;
            tb_mem[i] = w0;
            ref_mem[i] = w0;
        end
        tb_mem[64] = 32'h80FF_7F01;
        ref_mem[64] = 32'h80FF_7F01;

        reset_n = 1'b0;
        #1;
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.fault", {31'd0, rsp_fault}, 32'd0);
        chk("rst.we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst.addr", mem_address, 32'd0);
        chk("rst.wdata", mem_write_data, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_stats("rst");

        // Loads from 0x100 = 0x80FF7F01.
        do_req("lb100", 0, 2'd0, 0, 32'h100, 0);
        do_req("lb102", 0, 2'd0, 0, 32'h102, 0);
        do_req("lbu102", 0, 2'd0, 1, 32'h102, 0);
        do_req("lh102", 0, 2'd1, 0, 32'h102, 0);
        do_req("lhu102", 0, 2'd1, 1, 32'h102, 0);
        do_req("lw100", 0, 2'd2, 0, 32'h100, 0);
        chk("load.const_lb102", ref_load(2'd0, 0, 32'h102), 32'hFFFF_FFFF);
        chk("load.const_lh102", ref_load(2'd1, 0, 32'h102), 32'hFFFF_80FF);

        // Sub-word stores via read-modify-write.
        do_req("sb101", 1, 2'd0, 0, 32'h101, 32'h1234_56AB);
        chk("sb101.mem", tb_mem[64], 32'h80FF_AB01);
        do_req("sh102", 1, 2'd1, 0, 32'h102, 32'h0000_BEEF);
        chk("sh102.mem", tb_mem[64], 32'hBEEF_AB01);
        do_req("lw100b", 0, 2'd2, 0, 32'h100, 0);

        // Faults.
        do_req("sw102", 1, 2'd2, 0, 32'h102, 32'hDEAD_BEEF);
        do_req("lh101", 0, 2'd1, 0, 32'h101, 0);
        do_req("size11", 1, 2'd3, 0, 32'h100, 32'h1111_1111);
        chk("fault.mem", tb_mem[64], 32'hBEEF_AB01);
        check_stats("directed");

        // Reset pulsed during the READ cycle of a byte store.
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'd0; req_unsigned = 0;
        req_address = 32'h101; req_wdata = 32'h0000_0055;
        we0 = we_count;
        @(posedge clk);
        #1;
        req_valid = 0;
        @(negedge clk);
        chk("midrst.in_read_addr", mem_address, 32'h100);
        reset_n = 1'b0;
        #1;
        chk("midrst.we", {31'd0, mem_write_enable}, 32'd0);
        chk("midrst.ready", {31'd0, req_ready}, 32'd1);
        chk("midrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst.addr", mem_address, 32'd0);
        chk("midrst.wdata", mem_write_data, 32'd0);
        exp_loads = 0; exp_stores = 0; exp_faults = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst.no_write", we_count - we0, 0);
        chk("midrst.no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_req("midrst.lw", 0, 2'd2, 0, 32'h100, 0);

        // Ten back-to-back word loads with req_valid held high.
        exp_loads = 0; exp_stores = 0; exp_faults = 0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        accepts = 0; rsps = 0; cyc = 0; last = 0;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd2; req_unsigned = 0;
        req_address = 32'h100;
        while (accepts < 10 && cyc < 60) begin
            if (rsp_valid) begin
                rsps++;
                chk("b2b.rdata", rsp_rdata, ref_mem[64]);
            end
            if (req_ready) begin
                if (accepts > 0) chk("b2b.spacing", cyc - last, 3);
                last = cyc;
                accepts++;
            end
            @(posedge clk);
            #1;
            if (accepts == 10) req_valid = 0;
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) begin
                rsps++;
                chk("b2b.rdata", rsp_rdata, ref_mem[64]);
            end
            @(negedge clk);
        end
        chk("b2b.accepts", accepts, 10);
        chk("b2b.rsps", rsps, 10);
        exp_loads = 10;
        check_stats("b2b");

        // Randomized mix.
        for (int i = 0; i < 60; i++) begin
            do_req("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 63)), $urandom);
        end
        check_stats("rand");

        for (int i = 0; i < 256; i++) chk("final.mem", tb_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
